vx_alu_arb: RTL and testbench
=============================

VX_ALU_ARB -- requirements
Module: vx_alu_arb

Interface
REQ-001 Parameter NUM_REQS, default 4, number of issue requesters sharing one ALU request port; SHALL be >= 2.
REQ-002 Parameter DATAW, default 256, width of one flattened ALU request payload (uuid, wid, tmask, PC, next_PC, op fields, imm, tid, rs data, rd, wb).
REQ-003 Parameter SELW, default $clog2(NUM_REQS), width of the requester index.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 req_valid  input  NUM_REQS  per-requester request valid.
REQ-007 req_data  input  NUM_REQS*DATAW  requester i payload at bits [i*DATAW +: DATAW].
REQ-008 req_ready  output  NUM_REQS  per-requester accept; one-hot or zero.
REQ-009 out_valid  output  1  registered ALU request valid toward the ALU slave.
REQ-010 out_data  output  DATAW  registered payload of the granted request.
REQ-011 out_sel  output  SELW  index of the requester that out_data came from.
REQ-012 out_ready  input  1  ALU slave accept.
REQ-013 stall_clr  input  1  synchronous clear of stall_cnt.
REQ-014 stall_cnt  output  16  saturating count of output backpressure cycles.

Function
REQ-015 load_en SHALL equal (!out_valid || out_ready); the output register SHALL accept new data only when load_en = 1.
REQ-016 Round-robin pointer rr_ptr (SELW bits) SHALL select the grant g as the first index i with req_valid[i] = 1, scanning rr_ptr, rr_ptr+1, ... cyclically mod NUM_REQS.
REQ-017 req_ready[g] SHALL be 1 only when load_en = 1, reset is deasserted and req_valid[g] = 1; all other req_ready bits SHALL be 0.
REQ-018 On an edge with load_en = 1 and any req_valid = 1: out_valid <= 1, out_data <= payload g, out_sel <= g, rr_ptr <= (g+1) mod NUM_REQS (NUM_REQS-1 wraps to 0).
REQ-019 On an edge with load_en = 1 and no req_valid: out_valid <= 0; out_data, out_sel, rr_ptr SHALL hold.
REQ-020 On an edge with load_en = 0: out_valid, out_data, out_sel, rr_ptr SHALL hold; req_ready SHALL be all 0.
REQ-021 Latency from req accept to out_valid SHALL be exactly 1 cycle; throughput SHALL be 1 request/cycle while out_ready = 1.
REQ-022 Grant SHALL be recomputed every cycle (no lock); a requester withdrawing valid before accept loses nothing and gains no priority.
REQ-023 A requester holding req_valid continuously SHALL be accepted within NUM_REQS consecutive accepts.
REQ-024 stall_cnt SHALL increment by 1 on each edge with out_valid = 1 and out_ready = 0, saturating at 16'hFFFF.
REQ-025 stall_clr = 1 SHALL set stall_cnt <= 0 on that edge, taking priority over a simultaneous increment.
REQ-026 No combinational path SHALL exist from out_ready or req_valid to out_valid/out_data/out_sel; req_ready MAY depend combinationally on req_valid and out_ready.

Reset
REQ-027 reset = 0 SHALL immediately (asynchronously) force out_valid = 0, out_data = 0, out_sel = 0, rr_ptr = 0, stall_cnt = 0, req_ready = all 0.
REQ-028 A request held in the output register when reset asserts SHALL be dropped; requesters SHALL re-present it.
REQ-029 After reset deasserts, the first grant SHALL favour requester 0 (rr_ptr = 0).

Verification
REQ-030 NUM_REQS=4, all req_valid=1, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 every cycle after the first.
REQ-031 rr_ptr=0, only req_valid[2]=1 -> req_ready=4'b0100, next cycle out_sel=2, out_valid=1, rr_ptr=3.
REQ-032 rr_ptr=3, req_valid=4'b1001 continuous -> out_sel 3 then 0 (wrap), then 3.
REQ-033 out_valid=1, out_ready=0 for 5 cycles -> out_data/out_sel stable, req_ready=0, stall_cnt=5; then out_ready=1 with stall_clr=1 -> stall_cnt=0 and next request loaded.
REQ-034 out_ready=0 held 70000 cycles with out_valid=1 -> stall_cnt=16'hFFFF, no wrap.
REQ-035 reset pulsed low mid-stream between clock edges -> all outputs 0 without a clock edge; after release with all valid, first out_sel=0.

Source files
------------

// File: rtl/vx_alu_arb.sv
// vx_alu_arb: round-robin arbiter that lets NUM_REQS issue requesters share
// one registered ALU request port.
//
// Ports:
//   clk        - clock; all state updates on its rising edge
//   reset      - asynchronous active-low reset (0 = in reset)
//   req_valid  - per-requester request valid
//   req_data   - flattened payloads, requester i at [i*DATAW +: DATAW]
//   req_ready  - per-requester accept (one-hot or zero)
//   out_valid  - registered request valid toward the ALU
//   out_data   - registered payload of the granted request
//   out_sel    - index of the requester that out_data came from
//   out_ready  - ALU accept
//   stall_clr  - synchronous clear of stall_cnt
//   stall_cnt  - saturating count of output backpressure cycles
module vx_alu_arb #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 256,
   parameter int SELW     = $clog2(NUM_REQS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   output logic [NUM_REQS-1:0]       req_ready,
   output logic                      out_valid,
   output logic [DATAW-1:0]          out_data,
   output logic [SELW-1:0]           out_sel,
   input  logic                      out_ready,
   input  logic                      stall_clr,
   output logic [15:0]               stall_cnt
);

   logic [SELW-1:0] rr_ptr;
   logic [SELW-1:0] grant;
   logic [SELW-1:0] grant_next_ptr;
   logic            any_valid;
   logic            load_en;

   assign any_valid = |req_valid;
   assign load_en   = !out_valid || out_ready;

   // Scan offsets from the far end back to rr_ptr so the closest valid
   // requester (smallest cyclic offset) is the last assignment and wins.
   always_comb begin
      grant = '0;
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
         logic [SELW-1:0] idx;
         idx = SELW'((int'(rr_ptr) + k) % NUM_REQS);
         if (req_valid[idx]) begin
            grant = idx;
         end
      end
   end

   // Explicit wrap keeps the pointer correct for non-power-of-two NUM_REQS.
   always_comb begin
      if (grant == SELW'(NUM_REQS - 1)) begin
         grant_next_ptr = '0;
      end else begin
         grant_next_ptr = grant + SELW'(1);
      end
   end

   // Gated with reset so no requester sees an accept while in reset.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         req_ready[i] = load_en && reset && req_valid[i] && (grant == SELW'(i));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         rr_ptr    <= '0;
      end else if (load_en) begin
         if (any_valid) begin
            out_valid <= 1'b1;
            out_data  <= req_data[grant*DATAW +: DATAW];
            out_sel   <= grant;
            rr_ptr    <= grant_next_ptr;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vx_alu_arb.sv
// tb_vx_alu_arb: self-checking bench for vx_alu_arb (NUM_REQS=4, DATAW=256).
// A behavioural model tracks the expected registered outputs, the
// round-robin pointer and the stall counter from the arbitration rules.
module tb_vx_alu_arb;

   localparam int NUM_REQS = 4;
   localparam int DATAW    = 256;
   localparam int SELW     = 2;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQS-1:0]       req_valid;
   logic [NUM_REQS*DATAW-1:0] req_data;
   logic [NUM_REQS-1:0]       req_ready;
   logic                      out_valid;
   logic [DATAW-1:0]          out_data;
   logic [SELW-1:0]           out_sel;
   logic                      out_ready;
   logic                      stall_clr;
   logic [15:0]               stall_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   bit               m_valid;
   logic [DATAW-1:0] m_data;
   int               m_sel;
   int               m_ptr;
   int               m_stall;

   always #5 clk = ~clk;

   vx_alu_arb #(
      .NUM_REQS(NUM_REQS),
      .DATAW   (DATAW),
      .SELW    (SELW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_sel  (out_sel),
      .out_ready(out_ready),
      .stall_clr(stall_clr),
      .stall_cnt(stall_cnt)
   );

   function automatic int model_grant();
      for (int k = 0; k < NUM_REQS; k++) begin
         int i;
         i = (m_ptr + k) % NUM_REQS;
         if (req_valid[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [NUM_REQS-1:0] model_ready();
      logic [NUM_REQS-1:0] r;
      r = '0;
      if (reset && !(m_valid && !out_ready) && (req_valid != '0)) r[model_grant()] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
      m_stall = 0;
   endtask

   // Applies one rising edge to the model, using the inputs the DUT sampled.
   task automatic model_clock();
      bit load;
      int g;
      if (!reset) begin
         model_reset();
         return;
      end
      load = !m_valid || out_ready;
      if (stall_clr) m_stall = 0;
      else if (m_valid && !out_ready && m_stall < 16'hFFFF) m_stall++;
      if (load) begin
         if (req_valid != '0) begin
            g       = model_grant();
            m_valid = 1'b1;
            m_data  = req_data[g*DATAW +: DATAW];
            m_sel   = g;
            m_ptr   = (g + 1) % NUM_REQS;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   // Waits for the edge, advances the model, lands 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic random_data();
      for (int w = 0; w < NUM_REQS * DATAW / 32; w++) req_data[w*32 +: 32] = $urandom();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      req_valid = '0;
      out_ready = 1'b0;
      stall_clr = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      req_valid = '1;
      out_ready = 1'b1;
      random_data();
      #1;
      checks++;
      if (req_ready !== '0) begin
         errors++;
         $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b sel=%0d stall=%0d data_zero=%b want all 0",
                  out_valid, out_sel, stall_cnt, out_data == '0);
      end
      reset = 1'b1;
   endtask

   task automatic test_round_robin();
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      do_reset();
      req_valid = '1;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         random_data();
         #1;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sel !== exp_seq[c][SELW-1:0] || out_data !== m_data) begin
            errors++;
            $display("FAIL rr_seq cycle %0d: valid=%b sel=%0d want valid=1 sel=%0d data_ok=%b",
                     c, out_valid, out_sel, exp_seq[c], out_data === m_data);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      random_data();
      req_valid = 4'b0100;
      out_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL single_ready: got %b want 0100", req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== req_data[2*DATAW +: DATAW]) begin
         errors++;
         $display("FAIL single_out: valid=%b sel=%0d want valid=1 sel=2", out_valid, out_sel);
      end
      // Pointer should now be 3: with everyone requesting, 3 wins.
      req_valid = '1;
      #1;
      tick();
      checks++;
      if (out_sel !== 2'd3) begin
         errors++;
         $display("FAIL single_ptr: sel=%0d want 3", out_sel);
      end
   endtask

   task automatic test_wrap();
      int exp_seq[3] = '{3, 0, 3};
      do_reset();
      out_ready = 1'b1;
      req_valid = 4'b0100;
      random_data();
      #1;
      tick();
      req_valid = 4'b1001;
      for (int c = 0; c < 3; c++) begin
         random_data();
         #1;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sel !== exp_seq[c][SELW-1:0]) begin
            errors++;
            $display("FAIL wrap cycle %0d: valid=%b sel=%0d want valid=1 sel=%0d",
                     c, out_valid, out_sel, exp_seq[c]);
         end
      end
   endtask

   task automatic test_stall();
      logic [DATAW-1:0] held_data;
      logic [SELW-1:0]  held_sel;
      out_ready = 1'b1;
      stall_clr = 1'b1;
      req_valid = 4'(1 + $urandom_range(0, 14));
      random_data();
      #1;
      tick();
      held_data = m_data;
      held_sel  = m_sel[SELW-1:0];
      out_ready = 1'b0;
      stall_clr = 1'b0;
      for (int c = 0; c < 5; c++) begin
         req_valid = 4'(1 + $urandom_range(0, 14));
         random_data();
         #1;
         checks++;
         if (req_ready !== '0) begin
            errors++;
            $display("FAIL stall_ready cycle %0d: got %b want 0000", c, req_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== held_data || out_sel !== held_sel) begin
            errors++;
            $display("FAIL stall_hold cycle %0d: valid=%b sel=%0d want valid=1 sel=%0d data_ok=%b",
                     c, out_valid, out_sel, held_sel, out_data === held_data);
         end
      end
      checks++;
      if (stall_cnt !== 16'd5) begin
         errors++;
         $display("FAIL stall_count: got %0d want 5", stall_cnt);
      end
      out_ready = 1'b1;
      stall_clr = 1'b1;
      req_valid = 4'(1 + $urandom_range(0, 14));
      random_data();
      #1;
      tick();
      stall_clr = 1'b0;
      checks++;
      if (stall_cnt !== 16'd0 || out_valid !== 1'b1 || out_sel !== m_sel[SELW-1:0] ||
          out_data !== m_data) begin
         errors++;
         $display("FAIL stall_release: stall=%0d valid=%b sel=%0d want stall=0 valid=1 sel=%0d",
                  stall_cnt, out_valid, out_sel, m_sel);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         req_valid = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         stall_clr = ($urandom_range(0, 15) == 0);
         random_data();
         #1;
         checks++;
         if (req_ready !== model_ready()) begin
            errors++;
            $display("FAIL rand_ready cycle %0d: got %b want %b", c, req_ready, model_ready());
         end
         tick();
         checks++;
         if (out_valid !== m_valid || out_sel !== m_sel[SELW-1:0] || out_data !== m_data ||
             stall_cnt !== m_stall[15:0]) begin
            errors++;
            $display("FAIL rand_out cycle %0d: valid=%b sel=%0d stall=%0d want valid=%b sel=%0d stall=%0d data_ok=%b",
                     c, out_valid, out_sel, stall_cnt, m_valid, m_sel, m_stall, out_data === m_data);
         end
      end
      stall_clr = 1'b0;
   endtask

   task automatic test_fairness();
      int accepts_since = 0;
      for (int c = 0; c < 200; c++) begin
         req_valid = 4'($urandom_range(0, 15)) | 4'b0010;
         out_ready = ($urandom_range(0, 2) != 0);
         random_data();
         #1;
         if (req_ready != '0) accepts_since++;
         if (req_ready[1]) begin
            checks++;
            if (accepts_since > NUM_REQS) begin
               errors++;
               $display("FAIL fairness cycle %0d: accepts=%0d want <= %0d",
                        c, accepts_since, NUM_REQS);
            end
            accepts_since = 0;
         end
         tick();
      end
   endtask

   task automatic test_saturate();
      out_ready = 1'b1;
      stall_clr = 1'b1;
      req_valid = '1;
      #1;
      tick();
      out_ready = 1'b0;
      stall_clr = 1'b0;
      for (int c = 1; c <= 70000; c++) begin
         tick();
         if (c == 65534) begin
            checks++;
            if (stall_cnt !== 16'hFFFE) begin
               errors++;
               $display("FAIL sat_near: got %h want FFFE", stall_cnt);
            end
         end
      end
      checks++;
      if (stall_cnt !== 16'hFFFF || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL sat_final: stall=%h valid=%b want FFFF valid=1", stall_cnt, out_valid);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      req_valid = '1;
      for (int c = 0; c < 3; c++) begin
         random_data();
         #1;
         tick();
      end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || stall_cnt !== 16'd0 ||
          req_ready !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b sel=%0d stall=%0d ready=%b want all 0",
                  out_valid, out_sel, stall_cnt, req_ready);
      end
      reset = 1'b1;
      random_data();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== req_data[DATAW-1:0]) begin
         errors++;
         $display("FAIL async_first: valid=%b sel=%0d want valid=1 sel=0", out_valid, out_sel);
      end
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b0;
      stall_clr = 1'b0;
      model_reset();
      test_reset();
      test_round_robin();
      test_single();
      test_wrap();
      test_stall();
      test_random();
      test_fairness();
      test_saturate();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
